// File: rtl/ex_operand_stage.sv
// Purpose : ID/EX pipeline register plus operand select; MEM/WB forwarding feeds the execute-stage ALU.
// Latency : one cycle from an ID accept to the operands appearing at the ALU; forwarding is combinational.
// Backpr. : idReady drops while EX is held (!exReady) or on a load-use hazard; the hazard inserts one bubble.
//
// Ports
//   clk, rst                   rising-edge clock, asynchronous active-high reset
//   idValid / idReady          decode handshake
//   idPc .. idMemRead          decoded instruction fields, latched on accept
//   flush                      kill the instruction held in EX (the incoming one is dropped too)
//   memFwd*, wbFwd*            results in flight in MEM and WB (MEM has priority)
//   exReady / exValid          downstream handshake
//   aluIn1, aluIn2, aluControl ALU operands and op code, zeroed when EX is empty
//   exRdAddr, exRegWrite, exMemRead, exStoreData   side-band results for later stages
module ex_operand_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int FWD_ENABLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  idValid,
    output logic                  idReady,
    input  logic [XLEN-1:0]       idPc,
    input  logic [XLEN-1:0]       idRs1Data,
    input  logic [XLEN-1:0]       idRs2Data,
    input  logic [XLEN-1:0]       idImm,
    input  logic [REG_ADDR_W-1:0] idRs1Addr,
    input  logic [REG_ADDR_W-1:0] idRs2Addr,
    input  logic [REG_ADDR_W-1:0] idRdAddr,
    input  logic [3:0]            idAluControl,
    input  logic                  idUsePc,
    input  logic                  idUseImm,
    input  logic                  idRegWrite,
    input  logic                  idMemRead,
    input  logic                  flush,
    input  logic                  memFwdWe,
    input  logic [REG_ADDR_W-1:0] memFwdRd,
    input  logic [XLEN-1:0]       memFwdData,
    input  logic                  wbFwdWe,
    input  logic [REG_ADDR_W-1:0] wbFwdRd,
    input  logic [XLEN-1:0]       wbFwdData,
    input  logic                  exReady,
    output logic                  exValid,
    output logic [XLEN-1:0]       aluIn1,
    output logic [XLEN-1:0]       aluIn2,
    output logic [3:0]            aluControl,
    output logic [REG_ADDR_W-1:0] exRdAddr,
    output logic                  exRegWrite,
    output logic                  exMemRead,
    output logic [XLEN-1:0]       exStoreData
);

    // Latched instruction state
    logic                  valid_q,   valid_d;
    logic [XLEN-1:0]       pc_q,      pc_d;
    logic [XLEN-1:0]       rs1_q,     rs1_d;
    logic [XLEN-1:0]       rs2_q,     rs2_d;
    logic [XLEN-1:0]       imm_q,     imm_d;
    logic [REG_ADDR_W-1:0] rs1a_q,    rs1a_d;
    logic [REG_ADDR_W-1:0] rs2a_q,    rs2a_d;
    logic [REG_ADDR_W-1:0] rd_q,      rd_d;
    logic [3:0]            ctl_q,     ctl_d;
    logic                  use_pc_q,  use_pc_d;
    logic                  use_imm_q, use_imm_d;
    logic                  rw_q,      rw_d;
    logic                  mr_q,      mr_d;

    logic                  hazard;
    logic                  accept;
    logic [XLEN-1:0]       fwd_rs1;
    logic [XLEN-1:0]       fwd_rs2;

    // x0 is never forwarded; MEM is younger than WB so it wins.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] addr,
        input logic [XLEN-1:0]       raw,
        input logic                  m_we,
        input logic [REG_ADDR_W-1:0] m_rd,
        input logic [XLEN-1:0]       m_dat,
        input logic                  w_we,
        input logic [REG_ADDR_W-1:0] w_rd,
        input logic [XLEN-1:0]       w_dat
    );
        logic [XLEN-1:0] r;
        r = raw;
        if (addr != '0) begin
            if (m_we && (m_rd == addr)) begin
                r = m_dat;
            end else if (w_we && (w_rd == addr)) begin
                r = w_dat;
            end
        end
        return r;
    endfunction

    always_comb begin
        fwd_rs1 = rs1_q;
        fwd_rs2 = rs2_q;
        if (FWD_ENABLE != 0) begin
            fwd_rs1 = fwd_sel(rs1a_q, rs1_q, memFwdWe, memFwdRd, memFwdData,
                              wbFwdWe, wbFwdRd, wbFwdData);
            fwd_rs2 = fwd_sel(rs2a_q, rs2_q, memFwdWe, memFwdRd, memFwdData,
                              wbFwdWe, wbFwdRd, wbFwdData);
        end
    end

    // A load in EX cannot forward its data yet; rs1 only counts when it is really read.
    assign hazard = valid_q && mr_q && (rd_q != '0) && idValid &&
                    (((idRs1Addr == rd_q) && !idUsePc) || (idRs2Addr == rd_q));

    assign idReady = (!valid_q || exReady) && !hazard;
    assign accept  = idValid && idReady;

    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        imm_d     = imm_q;
        rs1a_d    = rs1a_q;
        rs2a_d    = rs2a_q;
        rd_d      = rd_q;
        ctl_d     = ctl_q;
        use_pc_d  = use_pc_q;
        use_imm_d = use_imm_q;
        rw_d      = rw_q;
        mr_d      = mr_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d   = 1'b1;
            pc_d      = idPc;
            rs1_d     = idRs1Data;
            rs2_d     = idRs2Data;
            imm_d     = idImm;
            rs1a_d    = idRs1Addr;
            rs2a_d    = idRs2Addr;
            rd_d      = idRdAddr;
            ctl_d     = idAluControl;
            use_pc_d  = idUsePc;
            use_imm_d = idUseImm;
            rw_d      = idRegWrite;
            mr_d      = idMemRead;
        end else if (exReady) begin
            // Covers both a plain drain and the load-use bubble.
            valid_d = 1'b0;
        end else if (valid_q) begin
            // Held: capture forwarded values so a WB result that is only
            // present for one cycle is not lost while we wait.
            rs1_d = fwd_rs1;
            rs2_d = fwd_rs2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            rs1a_q    <= '0;
            rs2a_q    <= '0;
            rd_q      <= '0;
            ctl_q     <= '0;
            use_pc_q  <= 1'b0;
            use_imm_q <= 1'b0;
            rw_q      <= 1'b0;
            mr_q      <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            imm_q     <= imm_d;
            rs1a_q    <= rs1a_d;
            rs2a_q    <= rs2a_d;
            rd_q      <= rd_d;
            ctl_q     <= ctl_d;
            use_pc_q  <= use_pc_d;
            use_imm_q <= use_imm_d;
            rw_q      <= rw_d;
            mr_q      <= mr_d;
        end
    end

    // Everything the ALU and later stages see is zero while EX is empty.
    assign exValid     = valid_q;
    assign aluIn1      = valid_q ? (use_pc_q  ? pc_q  : fwd_rs1) : '0;
    assign aluIn2      = valid_q ? (use_imm_q ? imm_q : fwd_rs2) : '0;
    assign exStoreData = valid_q ? fwd_rs2 : '0;
    assign aluControl  = valid_q ? ctl_q : 4'd0;
    assign exRdAddr    = valid_q ? rd_q : '0;
    assign exRegWrite  = valid_q && rw_q;
    assign exMemRead   = valid_q && mr_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        idValid, idReady;
    logic [31:0] idPc, idRs1Data, idRs2Data, idImm;
    logic [4:0]  idRs1Addr, idRs2Addr, idRdAddr;
    logic [3:0]  idAluControl;
    logic        idUsePc, idUseImm, idRegWrite, idMemRead;
    logic        flush;
    logic        memFwdWe, wbFwdWe;
    logic [4:0]  memFwdRd, wbFwdRd;
    logic [31:0] memFwdData, wbFwdData;
    logic        exReady, exValid;
    logic [31:0] aluIn1, aluIn2, exStoreData;
    logic [3:0]  aluControl;
    logic [4:0]  exRdAddr;
    logic        exRegWrite, exMemRead;

    always #5 clk = ~clk;

    ex_operand_stage #(.XLEN(32), .REG_ADDR_W(5), .FWD_ENABLE(1)) dut (
        .clk(clk), .rst(rst),
        .idValid(idValid), .idReady(idReady),
        .idPc(idPc), .idRs1Data(idRs1Data), .idRs2Data(idRs2Data), .idImm(idImm),
        .idRs1Addr(idRs1Addr), .idRs2Addr(idRs2Addr), .idRdAddr(idRdAddr),
        .idAluControl(idAluControl), .idUsePc(idUsePc), .idUseImm(idUseImm),
        .idRegWrite(idRegWrite), .idMemRead(idMemRead), .flush(flush),
        .memFwdWe(memFwdWe), .memFwdRd(memFwdRd), .memFwdData(memFwdData),
        .wbFwdWe(wbFwdWe), .wbFwdRd(wbFwdRd), .wbFwdData(wbFwdData),
        .exReady(exReady), .exValid(exValid),
        .aluIn1(aluIn1), .aluIn2(aluIn2), .aluControl(aluControl),
        .exRdAddr(exRdAddr), .exRegWrite(exRegWrite), .exMemRead(exMemRead),
        .exStoreData(exStoreData)
    );

    typedef struct packed {
        logic        use_pc;
        logic        use_imm;
        logic [31:0] pc;
        logic [4:0]  rs1a;
        logic [31:0] rs1;
        logic [4:0]  rs2a;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [3:0]  ctl;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mwe;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        logic        wwe;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        logic [31:0] e_in1;
        logic [31:0] e_in2;
        logic [31:0] e_st;
    } vec_t;

    typedef struct packed {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] st;
        logic [3:0]  ctl;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
    } exp_t;

    localparam int NV = 7;
    vec_t vt [NV];
    exp_t sb [$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic clear_all();
        idValid = 1'b0; idPc = '0; idRs1Data = '0; idRs2Data = '0; idImm = '0;
        idRs1Addr = '0; idRs2Addr = '0; idRdAddr = '0; idAluControl = '0;
        idUsePc = 1'b0; idUseImm = 1'b0; idRegWrite = 1'b0; idMemRead = 1'b0;
        flush = 1'b0;
        memFwdWe = 1'b0; memFwdRd = '0; memFwdData = '0;
        wbFwdWe = 1'b0; wbFwdRd = '0; wbFwdData = '0;
    endtask

    task automatic drive_ins(input vec_t v);
        idValid = 1'b1; idUsePc = v.use_pc; idUseImm = v.use_imm; idPc = v.pc;
        idRs1Addr = v.rs1a; idRs1Data = v.rs1; idRs2Addr = v.rs2a; idRs2Data = v.rs2;
        idImm = v.imm; idAluControl = v.ctl; idRdAddr = v.rd;
        idRegWrite = v.rw; idMemRead = v.mr;
    endtask

    task automatic set_fwd(input vec_t v);
        memFwdWe = v.mwe; memFwdRd = v.mrd; memFwdData = v.mdat;
        wbFwdWe = v.wwe; wbFwdRd = v.wrd; wbFwdData = v.wdat;
    endtask

    function automatic vec_t mk_ins(input logic [4:0] rs1a, input logic [31:0] rs1,
                                    input logic [4:0] rs2a, input logic [31:0] rs2,
                                    input logic [4:0] rd, input logic mr);
        vec_t v;
        v = '0;
        v.rs1a = rs1a; v.rs1 = rs1; v.rs2a = rs2a; v.rs2 = rs2;
        v.rd = rd; v.rw = 1'b1; v.mr = mr;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        exp_t e;
        // use_pc use_imm pc rs1a rs1 rs2a rs2 imm ctl rd rw mr | mwe mrd mdat wwe wrd wdat | exp in1 in2 st
        vt[0] = '{1'b0, 1'b0, 32'h0, 5'd1, 32'h11, 5'd2, 32'h22, 32'h0, 4'd3, 5'd4, 1'b1, 1'b1,
                  1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h11, 32'h22, 32'h22};
        vt[1] = '{1'b0, 1'b0, 32'h0, 5'd5, 32'h11, 5'd0, 32'h33, 32'h0, 4'd5, 5'd6, 1'b1, 1'b0,
                  1'b1, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB, 32'hAA, 32'h33, 32'h33};
        vt[2] = '{1'b0, 1'b0, 32'h0, 5'd5, 32'h11, 5'd0, 32'h33, 32'h0, 4'd0, 5'd1, 1'b0, 1'b0,
                  1'b0, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB, 32'hBB, 32'h33, 32'h33};
        vt[3] = '{1'b0, 1'b0, 32'h0, 5'd0, 32'h11, 5'd0, 32'h33, 32'h0, 4'd15, 5'd31, 1'b1, 1'b0,
                  1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB, 32'h11, 32'h33, 32'h33};
        vt[4] = '{1'b1, 1'b1, 32'h100, 5'd6, 32'h66, 5'd6, 32'h77, 32'hFFFFFFFC, 4'd2, 5'd3, 1'b1, 1'b0,
                  1'b1, 5'd6, 32'h5555, 1'b0, 5'd0, 32'h0, 32'h100, 32'hFFFFFFFC, 32'h5555};
        vt[5] = '{1'b0, 1'b0, 32'h0, 5'd8, 32'h1, 5'd9, 32'h99, 32'h0, 4'd8, 5'd9, 1'b0, 1'b0,
                  1'b1, 5'd8, 32'hA, 1'b1, 5'd9, 32'hB, 32'hA, 32'hB, 32'hB};
        vt[6] = '{1'b0, 1'b0, 32'h0, 5'd10, 32'h10, 5'd11, 32'h20, 32'h0, 4'd1, 5'd0, 1'b1, 1'b0,
                  1'b0, 5'd10, 32'hDEAD, 1'b1, 5'd11, 32'hBEEF, 32'h10, 32'hBEEF, 32'hBEEF};

        clear_all();
        exReady = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_exValid", 32'(exValid), 32'd0);
        chk("rst_aluIn1", aluIn1, 32'd0);
        chk("rst_aluIn2", aluIn2, 32'd0);
        chk("rst_store", exStoreData, 32'd0);
        chk("rst_ctl_rw", 32'({aluControl, exRegWrite, exMemRead, exRdAddr}), 32'd0);
        chk("rst_idReady", 32'(idReady), 32'd1);
        rst = 1'b0;

        // Table vectors: push expectation on accept, pop when EX presents it.
        for (int i = 0; i < NV; i++) begin
            set_fwd('0);
            exReady = 1'b1;
            drive_ins(vt[i]);
            #1;
            chk($sformatf("v%0d_idReady", i), 32'(idReady), 32'd1);
            e.in1 = vt[i].e_in1; e.in2 = vt[i].e_in2; e.st = vt[i].e_st;
            e.ctl = vt[i].ctl;   e.rd = vt[i].rd;     e.rw = vt[i].rw; e.mr = vt[i].mr;
            sb.push_back(e);
            @(posedge clk);
            #1;
            idValid = 1'b0;
            exReady = 1'b0;
            set_fwd(vt[i]);
            for (int c = 0; c < 8 && !exValid; c++) @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_exValid", i), 32'(exValid), 32'd1);
            if (exValid && sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("v%0d_aluIn1", i), aluIn1, e.in1);
                chk($sformatf("v%0d_aluIn2", i), aluIn2, e.in2);
                chk($sformatf("v%0d_store", i), exStoreData, e.st);
                chk($sformatf("v%0d_ctl", i), 32'(aluControl), 32'(e.ctl));
                chk($sformatf("v%0d_rd", i), 32'(exRdAddr), 32'(e.rd));
                chk($sformatf("v%0d_rw_mr", i), 32'({exRegWrite, exMemRead}), 32'({e.rw, e.mr}));
            end
        end
        clear_all();
        exReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("drain_exValid", 32'(exValid), 32'd0);
        chk("drain_aluIn1", aluIn1, 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        // Load-use: one bubble, then issue with the MEM forward.
        drive_ins(mk_ins(5'd1, 32'h1, 5'd2, 32'h2, 5'd7, 1'b1));
        @(posedge clk);
        #1;
        drive_ins(mk_ins(5'd3, 32'h3, 5'd7, 32'h70, 5'd8, 1'b0));
        @(negedge clk);
        chk("lu_load_in_ex", 32'({exValid, exMemRead}), 32'h3);
        chk("lu_idReady_low", 32'(idReady), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("lu_bubble", 32'(exValid), 32'd0);
        chk("lu_idReady_high", 32'(idReady), 32'd1);
        @(posedge clk);
        #1;
        idValid = 1'b0;
        exReady = 1'b0;
        memFwdWe = 1'b1; memFwdRd = 5'd7; memFwdData = 32'hCAFE;
        @(negedge clk);
        chk("lu_issue_valid", 32'(exValid), 32'd1);
        chk("lu_aluIn2", aluIn2, 32'hCAFE);
        chk("lu_store", exStoreData, 32'hCAFE);
        chk("lu_aluIn1", aluIn1, 32'h3);
        clear_all();
        exReady = 1'b1;

        // Load in EX but rs1 unused (PC select): no hazard.
        drive_ins(mk_ins(5'd1, 32'h1, 5'd2, 32'h2, 5'd7, 1'b1));
        @(posedge clk);
        #1;
        v = mk_ins(5'd7, 32'h0, 5'd0, 32'h0, 5'd9, 1'b0);
        v.use_pc = 1'b1;
        drive_ins(v);
        @(negedge clk);
        chk("usepc_no_hazard", 32'(idReady), 32'd1);
        @(posedge clk);
        #1;
        clear_all();
        @(posedge clk);

        // Stall refresh: WB forward present only in the first held cycle.
        @(negedge clk);
        drive_ins(mk_ins(5'd3, 32'h1, 5'd0, 32'h0, 5'd4, 1'b0));
        @(posedge clk);
        #1;
        idValid = 1'b0;
        exReady = 1'b0;
        wbFwdWe = 1'b1; wbFwdRd = 5'd3; wbFwdData = 32'h1234;
        @(negedge clk);
        chk("stall_c1", aluIn1, 32'h1234);
        @(posedge clk);
        #1;
        wbFwdWe = 1'b0; wbFwdData = 32'h0;
        @(negedge clk);
        chk("stall_c2", aluIn1, 32'h1234);
        @(posedge clk);
        @(negedge clk);
        chk("stall_c3", aluIn1, 32'h1234);
        chk("stall_held", 32'(exValid), 32'd1);
        exReady = 1'b1;
        #1;
        chk("stall_release", aluIn1, 32'h1234);
        @(posedge clk);
        @(negedge clk);
        chk("stall_consumed", 32'(exValid), 32'd0);

        // Flush on the same edge as an accept drops the instruction.
        drive_ins(mk_ins(5'd1, 32'h55, 5'd2, 32'h66, 5'd5, 1'b0));
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        idValid = 1'b0;
        @(negedge clk);
        chk("flush_exValid", 32'(exValid), 32'd0);
        chk("flush_aluIn1", aluIn1, 32'd0);
        chk("flush_rw", 32'(exRegWrite), 32'd0);

        // Asynchronous reset while EX is live, then a normal accept.
        drive_ins(mk_ins(5'd1, 32'h77, 5'd2, 32'h88, 5'd5, 1'b0));
        @(posedge clk);
        #1;
        idValid = 1'b0;
        exReady = 1'b0;
        #1;
        chk("mrst_pre_valid", 32'(exValid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mrst_exValid", 32'(exValid), 32'd0);
        chk("mrst_aluIn1", aluIn1, 32'd0);
        chk("mrst_aluIn2", aluIn2, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exReady = 1'b1;
        drive_ins(mk_ins(5'd1, 32'h99, 5'd2, 32'h12, 5'd6, 1'b0));
        @(posedge clk);
        #1;
        idValid = 1'b0;
        @(negedge clk);
        chk("mrst_after_valid", 32'(exValid), 32'd1);
        chk("mrst_after_in1", aluIn1, 32'h99);
        chk("mrst_after_in2", aluIn2, 32'h12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
